// File: rtl/gh_pkg.sv
// Shared types and constants for the game scoring path.
package gh_pkg;

  localparam int SCORE_W = 14;
  localparam int COMBO_W = 8;
  localparam int BCD_W   = 16;

  localparam int LANES_DEF      = 4;
  localparam int SCORE_MAX_DEF  = 9999;
  localparam int COMBO_STEP_DEF = 10;
  localparam int MULT_MAX_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // Number of set bits in an 8-bit vector (lane count is at most 8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to four BCD digits.
// One SHIFT cycle per input bit, then a single DONE cycle presenting the result.
module bin2bcd_seq
  import gh_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               abort,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  localparam logic [3:0] LAST_CNT = 4'(SCORE_W - 1);

  conv_state_t        r_state;
  conv_state_t        w_state_nx;
  logic [SCORE_W-1:0] r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   w_adj;
  logic [3:0]         r_cnt;

  // Add 3 to every digit that is 5 or more, ahead of the next shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_adj = r_bcd;
    for (int d = 0; d < 4; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) begin
        w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic; abort forces an immediate return to IDLE.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nx = SHIFT;
      SHIFT:   if (r_cnt == LAST_CNT) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (abort) begin
      w_state_nx = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Shift datapath: load on start, add-3-and-shift while in SHIFT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (abort) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin <= bin;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 4'd1;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign bcd  = r_bcd;

endmodule

// File: rtl/score_keeper.sv
// Per-player score, combo, multiplier and best-combo tracking, with a
// background BCD conversion of the score for the seven-segment path.
module score_keeper
  import gh_pkg::*;
#(
  parameter int LANES      = LANES_DEF,
  parameter int SCORE_MAX  = SCORE_MAX_DEF,
  parameter int COMBO_STEP = COMBO_STEP_DEF,
  parameter int MULT_MAX   = MULT_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               game_en,
  input  logic               clear,
  input  logic [LANES-1:0]   hit,
  input  logic [LANES-1:0]   miss,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [2:0]         multiplier,
  output logic [COMBO_W-1:0] max_combo,
  output logic [BCD_W-1:0]   score_bcd,
  output logic               bcd_valid,
  output logic               hit_flash
);

  localparam int                 SUM_W      = SCORE_W + 1;
  localparam logic [COMBO_W-1:0] STEP_L     = COMBO_W'(COMBO_STEP);
  localparam logic [COMBO_W-1:0] MULT_TOP_L = COMBO_W'(MULT_MAX - 1);
  localparam logic [SUM_W-1:0]   SAT_L      = SUM_W'(SCORE_MAX);

  logic [SCORE_W-1:0] r_score;
  logic [COMBO_W-1:0] r_combo;
  logic [COMBO_W-1:0] r_max;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_valid;
  logic               r_flash;
  logic               r_pending;

  logic [LANES-1:0]   w_h;
  logic [LANES-1:0]   w_m;
  logic [3:0]         w_nh;
  logic               w_any_miss;
  logic [COMBO_W-1:0] w_q;
  logic [2:0]         w_mult;
  logic [SUM_W-1:0]   w_sum;
  logic [SCORE_W-1:0] w_score_nx;
  logic [COMBO_W:0]   w_csum;
  logic [COMBO_W-1:0] w_combo_nx;
  logic [COMBO_W-1:0] w_max_nx;
  logic               w_score_chg;
  logic               w_start;
  logic               w_busy;
  logic               w_done;
  logic               w_take;
  logic [BCD_W-1:0]   w_conv_bcd;

  // Qualified lane events: a hit wins over a miss on the same lane.
  assign w_h        = hit & {LANES{game_en}};
  assign w_m        = miss & ~hit & {LANES{game_en}};
  assign w_nh       = popcount8(8'(w_h));
  assign w_any_miss = |w_m;

  // Multiplier steps up every COMBO_STEP consecutive hits, capped at MULT_MAX.
  assign w_q    = r_combo / STEP_L;
  assign w_mult = (w_q >= MULT_TOP_L) ? 3'(MULT_MAX) : (3'(w_q) + 3'd1);

  // Next score / combo / best-combo; the sum is one bit wider so saturation sees overflow.
  always_comb begin
    w_sum      = {1'b0, r_score} + (SUM_W'(w_nh) * SUM_W'(w_mult));
    w_score_nx = (w_sum > SAT_L) ? SCORE_W'(SCORE_MAX) : w_sum[SCORE_W-1:0];
    w_csum     = {1'b0, r_combo} + (COMBO_W + 1)'(w_nh);
    if (w_any_miss) begin
      w_combo_nx = '0;
    end else if (w_csum[COMBO_W]) begin
      w_combo_nx = '1;
    end else begin
      w_combo_nx = w_csum[COMBO_W-1:0];
    end
    w_max_nx = (w_combo_nx > r_max) ? w_combo_nx : r_max;
  end

  // Conversion handshake: a queued score goes out once the converter is idle,
  // and a result is only accepted if nothing changed while it was in flight.
  assign w_score_chg = (w_score_nx != r_score);
  assign w_start     = r_pending & ~w_busy & ~clear;
  assign w_take      = w_done & ~r_pending & ~w_score_chg;

  bin2bcd_seq u_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .abort   (clear),
    .start   (w_start),
    .bin     (r_score),
    .busy    (w_busy),
    .done    (w_done),
    .bcd     (w_conv_bcd)
  );

  // Game state registers; clear has priority over every other update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_score   <= '0;
      r_combo   <= '0;
      r_max     <= '0;
      r_flash   <= 1'b0;
    end else if (clear) begin
      r_score   <= '0;
      r_combo   <= '0;
      r_max     <= '0;
      r_flash   <= 1'b0;
    end else begin
      r_score   <= w_score_nx;
      r_combo   <= w_combo_nx;
      r_max     <= w_max_nx;
      r_flash   <= (w_nh != 4'd0);
    end
  end

  // Display-side BCD register, its valid flag and the pending-conversion flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd     <= '0;
      r_valid   <= 1'b1;
      r_pending <= 1'b0;
    end else if (clear) begin
      r_bcd     <= '0;
      r_valid   <= 1'b1;
      r_pending <= 1'b0;
    end else begin
      if (w_score_chg) begin
        r_pending <= 1'b1;
      end else if (w_start) begin
        r_pending <= 1'b0;
      end
      if (w_score_chg) begin
        r_valid <= 1'b0;
      end else if (w_take) begin
        r_valid <= 1'b1;
      end
      if (w_take) begin
        r_bcd <= w_conv_bcd;
      end
    end
  end

  assign score      = r_score;
  assign combo      = r_combo;
  assign multiplier = w_mult;
  assign max_combo  = r_max;
  assign score_bcd  = r_bcd;
  assign bcd_valid  = r_valid;
  assign hit_flash  = r_flash;

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with hand-computed expectations.
`timescale 1ns/1ps
module tb_score_keeper;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        game_en = 1'b1;
  logic        clear   = 1'b0;
  logic [3:0]  hit     = 4'b0;
  logic [3:0]  miss    = 4'b0;
  logic [13:0] score;
  logic [7:0]  combo;
  logic [2:0]  multiplier;
  logic [7:0]  max_combo;
  logic [15:0] score_bcd;
  logic        bcd_valid;
  logic        hit_flash;

  int n_checks = 0;
  int n_errors = 0;

  score_keeper dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .game_en    (game_en),
    .clear      (clear),
    .hit        (hit),
    .miss       (miss),
    .score      (score),
    .combo      (combo),
    .multiplier (multiplier),
    .max_combo  (max_combo),
    .score_bcd  (score_bcd),
    .bcd_valid  (bcd_valid),
    .hit_flash  (hit_flash)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] h, input logic [3:0] m);
    hit  = h;
    miss = m;
    tick();
    hit  = 4'b0;
    miss = 4'b0;
  endtask

  task automatic pulses(input int n, input logic [3:0] h);
    for (int i = 0; i < n; i++) pulse(h, 4'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Bounded wait for bcd_valid; an expired budget shows up as a failed check.
  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (!bcd_valid && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_valid"}, 32'(bcd_valid), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_score"}, 32'(score),      32'd0);
    check({tag, "_combo"}, 32'(combo),      32'd0);
    check({tag, "_mult"},  32'(multiplier), 32'd1);
    check({tag, "_max"},   32'(max_combo),  32'd0);
    check({tag, "_bcd"},   32'(score_bcd),  32'd0);
    check({tag, "_valid"}, 32'(bcd_valid),  32'd1);
    check({tag, "_flash"}, 32'(hit_flash),  32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_reset("in_reset");
    reset_n = 1'b1;
    tick();
    check_reset("post_reset");

    // Twelve single-lane hits: 10 at x1, 2 at x2 -> 14
    pulses(9, 4'b0001);
    check("s1_mult_at9", 32'(multiplier), 32'd1);
    pulse(4'b0001, 4'b0);
    check("s1_mult_at10", 32'(multiplier), 32'd2);
    check("s1_score_at10", 32'(score), 32'd10);
    pulses(2, 4'b0001);
    check("s1_score", 32'(score), 32'd14);
    check("s1_combo", 32'(combo), 32'd12);
    check("s1_flash", 32'(hit_flash), 32'd1);
    check("s1_valid_low", 32'(bcd_valid), 32'd0);
    tick();
    check("s1_flash_off", 32'(hit_flash), 32'd0);
    wait_valid("s1", 60);
    check("s1_bcd", 32'(score_bcd), 32'h0014);
    check("s1_max", 32'(max_combo), 32'd12);

    // Clear, then exact conversion latency for a lone hit
    do_clear();
    check("clr_score", 32'(score), 32'd0);
    check("clr_max", 32'(max_combo), 32'd0);
    check("clr_bcd", 32'(score_bcd), 32'd0);
    check("clr_valid", 32'(bcd_valid), 32'd1);
    pulse(4'b0001, 4'b0);
    repeat (15) tick();
    check("lat_n15_valid", 32'(bcd_valid), 32'd0);
    tick();
    check("lat_n16_valid", 32'(bcd_valid), 32'd1);
    check("lat_n16_bcd", 32'(score_bcd), 32'h0001);

    // combo 9, two hits in one cycle at x1
    pulses(8, 4'b0001);
    check("s2_combo9", 32'(combo), 32'd9);
    pulse(4'b0101, 4'b0);
    check("s2_score", 32'(score), 32'd11);
    check("s2_combo", 32'(combo), 32'd11);
    check("s2_mult", 32'(multiplier), 32'd2);

    // Build combo to 25: 9 hits x2, 5 hits x3 -> 11+18+15 = 44
    pulses(14, 4'b0001);
    check("s3_combo25", 32'(combo), 32'd25);
    check("s3_mult3", 32'(multiplier), 32'd3);
    check("s3_score44", 32'(score), 32'd44);
    pulse(4'b0010, 4'b1000);
    check("s3_hitmiss_score", 32'(score), 32'd47);
    check("s3_hitmiss_combo", 32'(combo), 32'd0);
    check("s3_hitmiss_max", 32'(max_combo), 32'd25);
    check("s3_hitmiss_mult", 32'(multiplier), 32'd1);
    pulse(4'b0010, 4'b0010);
    check("s3_collide_score", 32'(score), 32'd48);
    check("s3_collide_combo", 32'(combo), 32'd1);
    check("s3_collide_max", 32'(max_combo), 32'd25);
    wait_valid("s3", 60);
    check("s3_bcd", 32'(score_bcd), 32'h0048);

    // Hits every 5 cycles keep the converter restarting: 4+4+4+8 = 20
    do_clear();
    for (int i = 0; i < 4; i++) begin
      pulse(4'b1111, 4'b0);
      repeat (4) tick();
      check($sformatf("s4_valid_low_%0d", i), 32'(bcd_valid), 32'd0);
    end
    check("s4_score", 32'(score), 32'd20);
    wait_valid("s4", 60);
    check("s4_bcd", 32'(score_bcd), 32'h0020);

    // Clear in the middle of SHIFT
    pulse(4'b0001, 4'b0);
    repeat (3) tick();
    do_clear();
    check("s4_midclr_score", 32'(score), 32'd0);
    check("s4_midclr_bcd", 32'(score_bcd), 32'd0);
    check("s4_midclr_valid", 32'(bcd_valid), 32'd1);
    repeat (20) tick();
    check("s4_midclr_bcd_late", 32'(score_bcd), 32'd0);
    check("s4_midclr_valid_late", 32'(bcd_valid), 32'd1);

    // Saturation: 3, miss, +60 -> 63, 617 x 16 -> 9935, miss, +60 -> 9995
    pulses(3, 4'b0001);
    pulse(4'b0000, 4'b0001);
    check("s5_miss_combo", 32'(combo), 32'd0);
    pulses(30, 4'b0001);
    check("s5_score63", 32'(score), 32'd63);
    check("s5_mult4", 32'(multiplier), 32'd4);
    pulses(617, 4'b1111);
    check("s5_score9935", 32'(score), 32'd9935);
    check("s5_combo_sat", 32'(combo), 32'd255);
    check("s5_max_sat", 32'(max_combo), 32'd255);
    pulse(4'b0000, 4'b0100);
    pulses(30, 4'b0001);
    check("s5_score9995", 32'(score), 32'd9995);
    check("s5_mult4b", 32'(multiplier), 32'd4);
    pulse(4'b0011, 4'b0);
    check("s5_sat_score", 32'(score), 32'd9999);
    check("s5_sat_combo", 32'(combo), 32'd32);
    pulse(4'b0001, 4'b0);
    check("s5_hold_score", 32'(score), 32'd9999);
    check("s5_hold_combo", 32'(combo), 32'd33);
    check("s5_hold_flash", 32'(hit_flash), 32'd1);
    wait_valid("s5", 80);
    check("s5_bcd", 32'(score_bcd), 32'h9999);

    // game_en low: inputs ignored
    game_en = 1'b0;
    pulse(4'b1111, 4'b1111);
    check("ge_score", 32'(score), 32'd9999);
    check("ge_combo", 32'(combo), 32'd33);
    check("ge_flash", 32'(hit_flash), 32'd0);
    pulse(4'b0000, 4'b0001);
    check("ge_miss_combo", 32'(combo), 32'd33);
    check("ge_max", 32'(max_combo), 32'd255);
    game_en = 1'b1;

    // Asynchronous reset in the middle of SHIFT
    do_clear();
    pulse(4'b0001, 4'b0);
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("async_rst");
    #1;
    reset_n = 1'b1;
    repeat (20) tick();
    check("after_rst_valid", 32'(bcd_valid), 32'd1);
    check("after_rst_bcd", 32'(score_bcd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
